ddr_wr_ts_ctrl: RTL and testbench
=================================

Name: ddr_wr_ts_ctrl

Overview:
- Write-burst sequencer for the DDR output tristate registers (DQ and DQS paths), running in the SCLK domain.
- Accepts write-burst requests and counts out the write latency, DQS preamble, data beats and DQS postamble.
- Drives registered tristate controls into the TD inputs of the DQ and DQS tristate DDR registers, and the read strobe of the write-data FIFO.
- Active-high tristate convention: TS=1 means high-Z.

Parameters:
- BL_W, 4, width of burst-length field; a burst is REQ_LEN+1 beats, 1..2^BL_W.
- WL_W, 3, width of write-latency field.
- PRE_CYC, 1, DQS preamble length in SCLK cycles (1..4).
- POST_CYC, 1, DQS postamble length in SCLK cycles (1..4).

Ports:
- SCLK, input, 1, system clock; all state on rising edge.
- RSTN, input, 1, asynchronous active-low reset.
- REQ_VALID, input, 1, burst request valid.
- REQ_READY, output, 1, controller can accept a request.
- REQ_LEN, input, BL_W, beats minus one; sampled on accept.
- WL, input, WL_W, write latency in cycles; quasi-static, changed only while BUSY=0.
- TS_DQ, output, 1, to DQ tristate register TD; 1 = high-Z.
- TS_DQS, output, 1, to DQS tristate register TD; 1 = high-Z.
- DATA_RD, output, 1, write-FIFO pop, one per beat.
- BUSY, output, 1, state != IDLE.

Behaviour:
- Reset (RSTN=0, async), all outputs registered:
  - State IDLE; counters 0.
  - TS_DQ=1, TS_DQS=1, DATA_RD=0, BUSY=0, REQ_READY=0.
  - REQ_READY rises on the first SCLK edge after RSTN release.
- Accept occurs on an edge where REQ_VALID & REQ_READY; REQ_LEN is latched into the beat counter.
- States and transitions:
  - IDLE: REQ_READY=1. On accept, go to WAIT if WL>0, else PRE.
  - WAIT: WL cycles, all TS=1, then PRE.
  - PRE: PRE_CYC cycles, TS_DQS=0, TS_DQ=1, then BURST.
  - BURST: REQ_LEN+1 cycles, TS_DQ=0, TS_DQS=0, DATA_RD=1 each cycle.
  - POST: POST_CYC cycles, TS_DQS=0, TS_DQ=1, then IDLE.
- Latency: with WL=0, the first DATA_RD and TS_DQ=0 appear PRE_CYC+1 cycles after the accept edge.
- Back-to-back bursts:
  - REQ_READY is also 1 on the final BURST beat, but only when WL==0.
  - Accept on that beat reloads the beat counter and stays in BURST.
  - No preamble, no postamble; TS_DQ/TS_DQS stay 0 and DATA_RD is continuous.
- REQ_READY=0 in WAIT, PRE, POST, and non-final BURST beats.
- REQ_LEN=0 gives a 1-beat burst. REQ_LEN=all-ones gives 2^BL_W beats; the counter must not wrap early.
- Reset mid-burst: all outputs return to reset values immediately (async). The outstanding burst is dropped and not resumed; the FIFO owner flushes it.
- A WL change while BUSY=1 is illegal; an assertion flags it in simulation.

Optional Feature:
- Macro DDR_WR_TS_ODT_EN adds output ODT_EN (1 bit, reset 0).
  - Asserts on the cycle of entry into PRE (or BURST for direct reuse).
  - Stays high through the last POST cycle, plus one extra cycle.
- Without the macro, the port and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package ddr_wr_ts_pkg holds:
  - State enum (IDLE, WAIT, PRE, BURST, POST).
  - Default PRE_CYC/POST_CYC constants.
  - TS_HIZ=1'b1 / TS_DRV=1'b0 constants.
- Sub-module ddr_wr_ts_cnt: loadable down-counter with a terminal-count flag, width max(BL_W, WL_W, 3). One instance is shared by the WAIT/PRE/BURST/POST states.

Test Plan:
- Reset: RSTN low, then released → TS_DQ=TS_DQS=1, DATA_RD=0, BUSY=0; REQ_READY=1 one edge after release.
- WL=0, REQ_LEN=3, PRE_CYC=1, POST_CYC=1, single request → TS_DQS=0 for 6 cycles; TS_DQ=0 for 4 cycles; DATA_RD for exactly 4 cycles starting edge 2 after accept.
- WL=2, REQ_LEN=0 → 2 all-high-Z cycles, 1 preamble, 1 beat, 1 postamble, then IDLE; REQ_READY low throughout.
- WL=0, two requests (LEN=1, then LEN=2) with the second offered on the last beat → 5 contiguous DATA_RD cycles; TS_DQ stays 0 with no gap.
- REQ_LEN=15 → exactly 16 DATA_RD pulses.
- RSTN asserted during beat 2 of 8 → outputs high-Z/0 asynchronously; a fresh request after release runs normally.

Source files
------------

// File: rtl/ddr_wr_ts_pkg.sv
// Shared types and constants for the DDR write-burst tristate sequencer.
package ddr_wr_ts_pkg;

   typedef enum logic [2:0] {IDLE, WAIT, PRE, BURST, POST} state_e;

   localparam int unsigned PRE_CYC_DEF  = 1;
   localparam int unsigned POST_CYC_DEF = 1;

   localparam logic TS_HIZ = 1'b1;
   localparam logic TS_DRV = 1'b0;

   function automatic int unsigned cnt_width(input int unsigned bl_w, input int unsigned wl_w);
      int unsigned w;
      w = 3;
      if (bl_w > w) w = bl_w;
      if (wl_w > w) w = wl_w;
      return w;
   endfunction

endpackage

// File: rtl/ddr_wr_ts_cnt.sv
// Loadable down-counter that stops at zero; tc flags zero now, tc_nxt flags zero after this edge.
module ddr_wr_ts_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc,
   output logic         tc_nxt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc     = (cnt_q == '0);
   assign tc_nxt = (cnt_d == '0);

endmodule

// File: rtl/ddr_wr_ts_ctrl.sv
// Write-burst sequencer driving DQ/DQS tristate controls and write-FIFO pops.
// Optional ODT_EN output enabled by defining DDR_WR_TS_ODT_EN.
module ddr_wr_ts_ctrl
   import ddr_wr_ts_pkg::*;
#(
   parameter int unsigned BL_W     = 4,
   parameter int unsigned WL_W     = 3,
   parameter int unsigned PRE_CYC  = PRE_CYC_DEF,
   parameter int unsigned POST_CYC = POST_CYC_DEF
) (
   input  logic            SCLK,
   input  logic            RSTN,
   input  logic            REQ_VALID,
   output logic            REQ_READY,
   input  logic [BL_W-1:0] REQ_LEN,
   input  logic [WL_W-1:0] WL,
   output logic            TS_DQ,
   output logic            TS_DQS,
   output logic            DATA_RD,
   output logic            BUSY
`ifdef DDR_WR_TS_ODT_EN
  ,output logic            ODT_EN
`endif
);

   localparam int unsigned   CW        = cnt_width(BL_W, WL_W);
   localparam logic [CW-1:0] PRE_LOAD  = CW'(PRE_CYC - 1);
   localparam logic [CW-1:0] POST_LOAD = CW'(POST_CYC - 1);

   state_e          state_q, state_d;
   logic [BL_W-1:0] len_q, len_d;
   logic            ts_dq_q, ts_dq_d;
   logic            ts_dqs_q, ts_dqs_d;
   logic            data_rd_q, data_rd_d;
   logic            busy_q, busy_d;
   logic            req_ready_q, req_ready_d;
   logic            load;
   logic [CW-1:0]   load_val;
   logic            cnt_tc, cnt_tc_nxt;
   logic            accept;

   assign accept = REQ_VALID & req_ready_q;

   ddr_wr_ts_cnt #(.W(CW)) u_cnt (
      .clk      (SCLK),
      .rst_n    (RSTN),
      .load     (load),
      .load_val (load_val),
      .tc       (cnt_tc),
      .tc_nxt   (cnt_tc_nxt)
   );

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      load     = 1'b0;
      load_val = '0;
      case (state_q)
         IDLE: if (accept) begin
            len_d = REQ_LEN;
            load  = 1'b1;
            if (WL != '0) begin
               state_d  = WAIT;
               load_val = CW'(WL - WL_W'(1));
            end else begin
               state_d  = PRE;
               load_val = PRE_LOAD;
            end
         end
         WAIT: if (cnt_tc) begin
            state_d  = PRE;
            load     = 1'b1;
            load_val = PRE_LOAD;
         end
         PRE: if (cnt_tc) begin
            state_d  = BURST;
            load     = 1'b1;
            load_val = CW'(len_q);
         end
         BURST: if (cnt_tc) begin
            load = 1'b1;
            if (accept) begin
               len_d    = REQ_LEN;
               load_val = CW'(REQ_LEN);
            end else begin
               state_d  = POST;
               load_val = POST_LOAD;
            end
         end
         POST: if (cnt_tc) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and BUSY track the next state; pad controls are decoded from
   // the current state and so trail the state by one cycle.
   always_comb begin
      req_ready_d = (state_d == IDLE) ||
                    ((state_d == BURST) && cnt_tc_nxt && (WL == '0));
      busy_d      = (state_d != IDLE);
      ts_dq_d     = (state_q == BURST) ? TS_DRV : TS_HIZ;
      ts_dqs_d    = (state_q inside {PRE, BURST, POST}) ? TS_DRV : TS_HIZ;
      data_rd_d   = (state_q == BURST);
   end

   always_ff @(posedge SCLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= IDLE;
         len_q       <= '0;
         ts_dq_q     <= TS_HIZ;
         ts_dqs_q    <= TS_HIZ;
         data_rd_q   <= 1'b0;
         busy_q      <= 1'b0;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         ts_dq_q     <= ts_dq_d;
         ts_dqs_q    <= ts_dqs_d;
         data_rd_q   <= data_rd_d;
         busy_q      <= busy_d;
         req_ready_q <= req_ready_d;
      end
   end

   assign REQ_READY = req_ready_q;
   assign TS_DQ     = ts_dq_q;
   assign TS_DQS    = ts_dqs_q;
   assign DATA_RD   = data_rd_q;
   assign BUSY      = busy_q;

`ifdef DDR_WR_TS_ODT_EN
   logic odt_q, odt_d;

   // Follows DQS drive and holds one cycle past its release.
   always_comb begin
      odt_d = (ts_dqs_d == TS_DRV) || (ts_dqs_q == TS_DRV);
   end

   always_ff @(posedge SCLK or negedge RSTN) begin
      if (!RSTN)
         odt_q <= 1'b0;
      else
         odt_q <= odt_d;
   end

   assign ODT_EN = odt_q;
`endif

   wl_stable_a: assert property (@(posedge SCLK) disable iff (!RSTN) busy_q |-> $stable(WL));

endmodule

// File: tb/tb_ddr_wr_ts_ctrl.sv
// Directed self-checking bench for ddr_wr_ts_ctrl (default build, PRE_CYC=POST_CYC=1).
module tb_ddr_wr_ts_ctrl;

   logic       SCLK = 1'b0;
   logic       RSTN = 1'b0;
   logic       REQ_VALID = 1'b0;
   logic       REQ_READY;
   logic [3:0] REQ_LEN = '0;
   logic [2:0] WL = '0;
   logic       TS_DQ, TS_DQS, DATA_RD, BUSY;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   int n_rd, n_dq, n_dqs, n_rise, n_rb, n_busy, first_rd, first_dqs, first_rb;

   ddr_wr_ts_ctrl #(.BL_W(4), .WL_W(3), .PRE_CYC(1), .POST_CYC(1)) dut (
      .SCLK      (SCLK),
      .RSTN      (RSTN),
      .REQ_VALID (REQ_VALID),
      .REQ_READY (REQ_READY),
      .REQ_LEN   (REQ_LEN),
      .WL        (WL),
      .TS_DQ     (TS_DQ),
      .TS_DQS    (TS_DQS),
      .DATA_RD   (DATA_RD),
      .BUSY      (BUSY)
   );

   always #5 SCLK = ~SCLK;

   task automatic tick();
      @(posedge SCLK);
      #1;
   endtask

   // Waits (bounded) for REQ_READY, then presents one request for one edge.
   task automatic request(input logic [3:0] len, output bit ok);
      int unsigned w;
      w = 0;
      while (REQ_READY !== 1'b1 && w < 50) begin
         tick();
         w++;
      end
      ok = (REQ_READY === 1'b1);
      REQ_VALID = 1'b1;
      REQ_LEN   = len;
      tick();
      REQ_VALID = 1'b0;
   endtask

   // Samples n cycles after the accept edge; optionally offers a second
   // request the first time REQ_READY is seen while BUSY.
   task automatic observe(input int n, input bit offer, input logic [3:0] offer_len);
      logic prev_rd;
      bit   offered;
      n_rd = 0; n_dq = 0; n_dqs = 0; n_rise = 0; n_rb = 0; n_busy = 0;
      first_rd = -1; first_dqs = -1; first_rb = -1;
      prev_rd = DATA_RD;
      offered = 1'b0;
      for (int k = 1; k <= n; k++) begin
         tick();
         REQ_VALID = 1'b0;
         if (DATA_RD === 1'b1) begin
            n_rd++;
            if (first_rd < 0) first_rd = k;
            if (prev_rd !== 1'b1) n_rise++;
         end
         prev_rd = DATA_RD;
         if (TS_DQ === 1'b0) n_dq++;
         if (TS_DQS === 1'b0) begin
            n_dqs++;
            if (first_dqs < 0) first_dqs = k;
         end
         if (BUSY === 1'b1) n_busy++;
         if (REQ_READY === 1'b1 && BUSY === 1'b1) begin
            n_rb++;
            if (first_rb < 0) first_rb = k;
            if (offer && !offered) begin
               REQ_VALID = 1'b1;
               REQ_LEN   = offer_len;
               offered   = 1'b1;
            end
         end
      end
   endtask

   task automatic test_reset();
      RSTN = 1'b0;
      tick();
      tick();
      n_total++; if (TS_DQ !== 1'b1) $display("FAIL reset_ts_dq: got %b want 1", TS_DQ); else n_pass++;
      n_total++; if (TS_DQS !== 1'b1) $display("FAIL reset_ts_dqs: got %b want 1", TS_DQS); else n_pass++;
      n_total++; if (DATA_RD !== 1'b0) $display("FAIL reset_data_rd: got %b want 0", DATA_RD); else n_pass++;
      n_total++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else n_pass++;
      n_total++; if (REQ_READY !== 1'b0) $display("FAIL reset_ready: got %b want 0", REQ_READY); else n_pass++;
      RSTN = 1'b1;
      #2;
      n_total++; if (REQ_READY !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", REQ_READY); else n_pass++;
      tick();
      n_total++; if (REQ_READY !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", REQ_READY); else n_pass++;
   endtask

   task automatic test_single();
      bit ok;
      WL = 3'd0;
      request(4'd3, ok);
      n_total++; if (!ok) $display("FAIL single_ready_timeout: got 0 want 1"); else n_pass++;
      n_total++; if (BUSY !== 1'b1) $display("FAIL single_busy_accept: got %b want 1", BUSY); else n_pass++;
      n_total++; if (REQ_READY !== 1'b0) $display("FAIL single_ready_accept: got %b want 0", REQ_READY); else n_pass++;
      observe(12, 1'b0, 4'd0);
      n_total++; if (n_dqs != 6) $display("FAIL single_dqs_cycles: got %0d want 6", n_dqs); else n_pass++;
      n_total++; if (n_dq != 4) $display("FAIL single_dq_cycles: got %0d want 4", n_dq); else n_pass++;
      n_total++; if (n_rd != 4) $display("FAIL single_rd_count: got %0d want 4", n_rd); else n_pass++;
      n_total++; if (first_rd != 2) $display("FAIL single_first_rd: got %0d want 2", first_rd); else n_pass++;
      n_total++; if (first_dqs != 1) $display("FAIL single_first_dqs: got %0d want 1", first_dqs); else n_pass++;
      n_total++; if (n_rb != 1) $display("FAIL single_ready_last_beat: got %0d want 1", n_rb); else n_pass++;
      n_total++; if (n_busy != 5) $display("FAIL single_busy_cycles: got %0d want 5", n_busy); else n_pass++;
      n_total++; if (TS_DQS !== 1'b1 || REQ_READY !== 1'b1) $display("FAIL single_end_idle: got dqs=%b rdy=%b want 1/1", TS_DQS, REQ_READY); else n_pass++;
   endtask

   task automatic test_wait();
      bit ok;
      WL = 3'd2;
      request(4'd0, ok);
      n_total++; if (!ok) $display("FAIL wait_ready_timeout: got 0 want 1"); else n_pass++;
      n_total++; if (BUSY !== 1'b1 || REQ_READY !== 1'b0) $display("FAIL wait_accept: got busy=%b rdy=%b want 1/0", BUSY, REQ_READY); else n_pass++;
      observe(10, 1'b0, 4'd0);
      n_total++; if (first_dqs != 3) $display("FAIL wait_first_dqs: got %0d want 3", first_dqs); else n_pass++;
      n_total++; if (n_dqs != 3) $display("FAIL wait_dqs_cycles: got %0d want 3", n_dqs); else n_pass++;
      n_total++; if (first_rd != 4) $display("FAIL wait_first_rd: got %0d want 4", first_rd); else n_pass++;
      n_total++; if (n_rd != 1 || n_dq != 1) $display("FAIL wait_beats: got rd=%0d dq=%0d want 1/1", n_rd, n_dq); else n_pass++;
      n_total++; if (n_rb != 0) $display("FAIL wait_ready_while_busy: got %0d want 0", n_rb); else n_pass++;
      n_total++; if (n_busy != 4) $display("FAIL wait_busy_cycles: got %0d want 4", n_busy); else n_pass++;
      WL = 3'd0;
   endtask

   task automatic test_back_to_back();
      bit ok;
      WL = 3'd0;
      request(4'd1, ok);
      n_total++; if (!ok) $display("FAIL b2b_ready_timeout: got 0 want 1"); else n_pass++;
      observe(14, 1'b1, 4'd2);
      n_total++; if (first_rb != 2) $display("FAIL b2b_ready_cycle: got %0d want 2", first_rb); else n_pass++;
      n_total++; if (n_rd != 5) $display("FAIL b2b_rd_count: got %0d want 5", n_rd); else n_pass++;
      n_total++; if (n_rise != 1) $display("FAIL b2b_rd_contiguous: got %0d bursts want 1", n_rise); else n_pass++;
      n_total++; if (n_dq != 5) $display("FAIL b2b_dq_cycles: got %0d want 5", n_dq); else n_pass++;
      n_total++; if (n_dqs != 7) $display("FAIL b2b_dqs_cycles: got %0d want 7", n_dqs); else n_pass++;
   endtask

   task automatic test_long_burst();
      bit ok;
      request(4'd15, ok);
      n_total++; if (!ok) $display("FAIL long_ready_timeout: got 0 want 1"); else n_pass++;
      observe(30, 1'b0, 4'd0);
      n_total++; if (n_rd != 16) $display("FAIL long_rd_count: got %0d want 16", n_rd); else n_pass++;
      n_total++; if (n_rise != 1) $display("FAIL long_rd_contiguous: got %0d bursts want 1", n_rise); else n_pass++;
      n_total++; if (n_dqs != 18) $display("FAIL long_dqs_cycles: got %0d want 18", n_dqs); else n_pass++;
      n_total++; if (n_busy != 17) $display("FAIL long_busy_cycles: got %0d want 17", n_busy); else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      request(4'd7, ok);
      n_total++; if (!ok) $display("FAIL mid_ready_timeout: got 0 want 1"); else n_pass++;
      tick(); tick(); tick();
      n_total++; if (DATA_RD !== 1'b1) $display("FAIL mid_beat2_rd: got %b want 1", DATA_RD); else n_pass++;
      RSTN = 1'b0;
      #1;
      n_total++; if (TS_DQ !== 1'b1 || TS_DQS !== 1'b1) $display("FAIL mid_async_ts: got dq=%b dqs=%b want 1/1", TS_DQ, TS_DQS); else n_pass++;
      n_total++; if (DATA_RD !== 1'b0) $display("FAIL mid_async_rd: got %b want 0", DATA_RD); else n_pass++;
      n_total++; if (BUSY !== 1'b0 || REQ_READY !== 1'b0) $display("FAIL mid_async_busy_ready: got %b/%b want 0/0", BUSY, REQ_READY); else n_pass++;
      tick(); tick();
      RSTN = 1'b1;
      tick();
      request(4'd1, ok);
      n_total++; if (!ok) $display("FAIL mid_restart_timeout: got 0 want 1"); else n_pass++;
      observe(10, 1'b0, 4'd0);
      n_total++; if (n_rd != 2 || first_rd != 2) $display("FAIL mid_restart_rd: got n=%0d first=%0d want 2/2", n_rd, first_rd); else n_pass++;
      n_total++; if (n_dqs != 4) $display("FAIL mid_restart_dqs: got %0d want 4", n_dqs); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_wait();
      test_back_to_back();
      test_long_burst();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
